key_event_array: RTL
====================

Name: key_event_array

Overview:
- Parametrised multi-key input conditioner; the successor to the single-key, falling-edge-only debouncer.
- Handles NUM_KEYS raw push-buttons or switches, each with:
  - selectable polarity;
  - metastability synchroniser;
  - counter debounce;
  - press, release, long-press and auto-repeat event pulses.
- Sits in the board top level between the KEY/SW pins and the control FSMs (record/play/stop, speed select), on the 12 MHz audio clock domain.

Parameters:
- NUM_KEYS, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, flip-flops in the input synchroniser (>=2).
- DEB_CYCLES, 120000, consecutive stable cycles required to accept a new level (10 ms at 12 MHz; >=1).
- LONG_CYCLES, 6000000, cycles held after o_press before o_long fires (0.5 s; >DEB_CYCLES).
- REPEAT_CYCLES, 1200000, period of o_repeat after o_long (0.1 s; >=1).
- ACTIVE_LOW, 1, 1 means pin low = pressed (DE2-115 KEY); 0 means pin high = pressed.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_keys  in  NUM_KEYS  raw asynchronous key pins.
- i_repeat_en  in  NUM_KEYS  per-key auto-repeat enable; synchronous, sampled every cycle.
- o_level  out  NUM_KEYS  debounced pressed level (1 = pressed).
- o_press  out  NUM_KEYS  one-cycle pulse on accepted press.
- o_release  out  NUM_KEYS  one-cycle pulse on accepted release.
- o_long  out  NUM_KEYS  one-cycle pulse, LONG_CYCLES after o_press, if still held.
- o_repeat  out  NUM_KEYS  one-cycle pulse every REPEAT_CYCLES after o_long while held and i_repeat_en set.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - i_rst asynchronously clears every register: synchroniser to the "released" level, counters to 0, state to KS_IDLE, all outputs 0.
- Per-channel pipeline:
  - Polarity normalisation: pressed = ACTIVE_LOW ? ~pin : pin.
  - Then the SYNC_STAGES-deep synchroniser, giving a signal `raw`.
- Debounce:
  - Counter deb_cnt, width $clog2(DEB_CYCLES+1).
  - If raw == o_level, deb_cnt <= 0.
  - Otherwise deb_cnt increments.
  - When deb_cnt == DEB_CYCLES-1 and raw still differs: o_level <= raw, deb_cnt <= 0, and the matching o_press/o_release is registered on the same edge.
  - Any glitch back to o_level restarts the count.
- Latency: a clean level change first sampled at edge 0 appears on o_level and on the event pulse after edge SYNC_STAGES+DEB_CYCLES-1. The pulse is high for exactly one cycle.
- Hold FSM, per key (KS_IDLE, KS_HELD, KS_LONG):
  - KS_IDLE -> KS_HELD on accepted press; hold_cnt <= 0.
  - KS_HELD: hold_cnt increments each cycle.
    - At hold_cnt == LONG_CYCLES-1: pulse o_long, go to KS_LONG, hold_cnt <= 0.
    - On accepted release: pulse o_release, go to KS_IDLE. No o_long is issued.
  - KS_LONG: hold_cnt counts modulo REPEAT_CYCLES.
    - At the wrap, o_repeat pulses if i_repeat_en[k] is 1 in that cycle. The counter wraps regardless of i_repeat_en.
    - On accepted release: pulse o_release, go to KS_IDLE.
- Pulse exclusivity:
  - o_press, o_release, o_long and o_repeat are mutually exclusive per key in any cycle.
  - A release accepted in the same cycle the long/repeat count would fire wins; the long/repeat pulse is suppressed.
- Channel independence:
  - Channels are fully independent.
  - Simultaneous events on different keys produce simultaneous pulses; there is no arbitration.
- Key held through reset: after i_rst deasserts, the held key is seen as a new press and o_press fires at the standard latency.
- Hold counter: hold_cnt width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)). It saturates nowhere and wraps only as defined above.
- Elaboration checks: parameter violations (listed ranges) cause $error at elaboration.

Decomposition:
- Package key_pkg holds:
  - typedef enum logic [1:0] key_state_e {KS_IDLE, KS_HELD, KS_LONG};
  - a counter-width helper function;
  - default timing constants for 12 MHz.
- One sub-module, key_channel: synchroniser + debounce + hold FSM for a single key. key_event_array instantiates it NUM_KEYS times via generate.

Test Plan:
Bench settings for all scenarios: NUM_KEYS=4, SYNC_STAGES=2, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1.
- Clean press: key0 driven 0 from edge 0 and held -> o_press[0] high only in the cycle after edge 5; o_level[0]=1 from then on; other keys stay silent.
- Bounce: key1 toggled every 2 cycles for 12 cycles, then steady 0 -> exactly one o_press[1], 4 stable cycles (plus sync) after the last toggle; no o_release.
- Long/repeat:
  - Hold key0 for 60 cycles past o_press with i_repeat_en[0]=0 -> single o_long 20 cycles after o_press; no o_repeat.
  - Repeat with i_repeat_en[0]=1 -> o_repeat at o_long+8, +16, +24, ...
- Release: key0 released while in KS_LONG -> one o_release at latency 6; o_level[0]=0; the next press needs a fresh 20 cycles for o_long.
- Simultaneous plus short press: keys 2 and 3 pressed on the same edge, key3 released after 10 cycles -> o_press[2] and o_press[3] on the same cycle; o_release[3] at latency 6; no o_long[3]; o_long[2] arrives normally.
- Reset mid-hold: assert i_rst asynchronously while key0 is in KS_LONG -> all outputs 0 with no clock edge. Deassert with key0 still 0 -> o_press[0] after edge 5 post-reset.

Source files
------------

// File: rtl/key_event_array_pkg.sv
// Shared types and 12 MHz timing defaults
// for the multi-key input conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_HELD,
    KS_LONG
  } key_state_e;

  localparam int DEF_NUM_KEYS      = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_DEB_CYCLES    = 120000;
  localparam int DEF_LONG_CYCLES   = 6000000;
  localparam int DEF_REPEAT_CYCLES = 1200000;
  localparam bit DEF_ACTIVE_LOW    = 1'b1;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_i(input int a,
                               input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_array_if.sv
// Key pins in, conditioned levels and
// event pulses out, one bit per key.
interface key_event_array_if #(
  parameter int NUM_KEYS = 4
);

  logic [NUM_KEYS-1:0] i_keys;
  logic [NUM_KEYS-1:0] i_repeat_en;
  logic [NUM_KEYS-1:0] o_level;
  logic [NUM_KEYS-1:0] o_press;
  logic [NUM_KEYS-1:0] o_release;
  logic [NUM_KEYS-1:0] o_long;
  logic [NUM_KEYS-1:0] o_repeat;

  modport master (
    output i_keys,
    output i_repeat_en,
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_long,
    input  o_repeat
  );

  modport slave (
    input  i_keys,
    input  i_repeat_en,
    output o_level,
    output o_press,
    output o_release,
    output o_long,
    output o_repeat
  );

endinterface

// File: rtl/key_event_array_channel.sv
// One key: synchroniser, counter debounce
// and press/long/repeat hold FSM.
module key_channel
  import key_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int DW = cnt_w(DEB_CYCLES + 1);
  localparam int HW =
    cnt_w(max_i(LONG_CYCLES, REPEAT_CYCLES));

  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST =
    HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST =
    HW'(REPEAT_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be >= 1");
  end
  if (LONG_CYCLES <= DEB_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must be > DEB_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("REPEAT_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_deb;
  logic [HW-1:0]          r_hold;
  key_state_e             r_state;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_long;
  logic                   r_repeat;

  logic [DW-1:0] w_deb_n;
  logic [HW-1:0] w_hold_n;
  key_state_e    w_state_n;
  logic          w_pressed;
  logic          w_raw;
  logic          w_diff;
  logic          w_acc;
  logic          w_level_n;
  logic          w_press_n;
  logic          w_release_n;
  logic          w_long_n;
  logic          w_repeat_n;

  assign w_pressed = ACTIVE_LOW ? ~i_pin : i_pin;
  assign w_raw     = r_sync[SYNC_STAGES-1];
  assign w_diff    = w_raw != r_level;
  assign w_acc     = w_diff && (r_deb == DEB_LAST);

  always_comb begin
    w_deb_n     = r_deb;
    w_level_n   = r_level;
    w_press_n   = 1'b0;
    w_release_n = 1'b0;
    w_long_n    = 1'b0;
    w_repeat_n  = 1'b0;
    w_state_n   = r_state;
    w_hold_n    = r_hold;

    if (!w_diff || w_acc) begin
      w_deb_n = '0;
    end else begin
      w_deb_n = r_deb + 1'b1;
    end

    if (w_acc) begin
      w_level_n   = w_raw;
      w_press_n   = w_raw;
      w_release_n = ~w_raw;
    end

    // a release on the same edge beats long/repeat
    unique case (r_state)
      KS_IDLE: begin
        if (w_press_n) begin
          w_state_n = KS_HELD;
          w_hold_n  = '0;
        end
      end
      KS_HELD: begin
        if (w_release_n) begin
          w_state_n = KS_IDLE;
          w_hold_n  = '0;
        end else if (r_hold == LONG_LAST) begin
          w_long_n  = 1'b1;
          w_state_n = KS_LONG;
          w_hold_n  = '0;
        end else begin
          w_hold_n = r_hold + 1'b1;
        end
      end
      KS_LONG: begin
        if (w_release_n) begin
          w_state_n = KS_IDLE;
          w_hold_n  = '0;
        end else if (r_hold == REP_LAST) begin
          w_repeat_n = i_repeat_en;
          w_hold_n   = '0;
        end else begin
          w_hold_n = r_hold + 1'b1;
        end
      end
      default: begin
        w_state_n = KS_IDLE;
        w_hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync    <= '0;
      r_deb     <= '0;
      r_hold    <= '0;
      r_state   <= KS_IDLE;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0],
                    w_pressed};
      r_deb     <= w_deb_n;
      r_hold    <= w_hold_n;
      r_state   <= w_state_n;
      r_level   <= w_level_n;
      r_press   <= w_press_n;
      r_release <= w_release_n;
      r_long    <= w_long_n;
      r_repeat  <= w_repeat_n;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/key_event_array.sv
// NUM_KEYS independent key channels behind
// one pin/event interface.
module key_event_array
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = DEF_NUM_KEYS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input logic          i_clk,
  input logic          i_rst,
  key_event_array_if.slave bus
);

  if (NUM_KEYS < 1) begin : g_bad_nk
    $error("NUM_KEYS must be >= 1");
  end
  if ($bits(bus.i_keys) != NUM_KEYS) begin : g_bad_if
    $error("interface width != NUM_KEYS");
  end

  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] w_long;
  logic [NUM_KEYS-1:0] w_repeat;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_pin      (bus.i_keys[g]),
      .i_repeat_en(bus.i_repeat_en[g]),
      .o_level    (w_level[g]),
      .o_press    (w_press[g]),
      .o_release  (w_release[g]),
      .o_long     (w_long[g]),
      .o_repeat   (w_repeat[g])
    );
  end

  assign bus.o_level   = w_level;
  assign bus.o_press   = w_press;
  assign bus.o_release = w_release;
  assign bus.o_long    = w_long;
  assign bus.o_repeat  = w_repeat;

endmodule
